// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers,
// framing each grant as an optional source-tag byte followed by the data byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLOCKS_PER_BIT = 217,
  parameter int TAG_EN         = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_byte,
  output logic [NUM_REQ-1:0]         o_req_ack,
  output logic                       o_TX_Data_Valid,
  output logic [7:0]                 o_TX_Byte,
  input  logic                       i_TX_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int ID_W           = $clog2(NUM_REQ);
  localparam int HOLD_CYCLES    = 11 * CLOCKS_PER_BIT;
  localparam int TIMEOUT_CYCLES = 12 * CLOCKS_PER_BIT;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    IDLE      = 3'd1,
    SEND_TAG  = 3'd2,
    WAIT_TAG  = 3'd3,
    SEND_DATA = 3'd4,
    WAIT_DATA = 3'd5
  } state_t;

  state_t     state_reg, state_next;
  cnt_t       cnt_reg, cnt_next;
  id_t        ptr_reg, ptr_next;
  id_t        id_reg, id_next;
  logic [7:0] data_reg, data_next;
  logic [7:0] tx_byte_reg, tx_byte_next;
  logic       timeout_reg, timeout_next;

  logic [7:0] req_bytes [NUM_REQ];
  logic       found;
  id_t        sel_id;
  logic [ID_W:0] idx;
  id_t        cand;
  id_t        ptr_after;
  logic       ack_phase;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi] = i_req_byte[8*gi +: 8];
      assign o_req_ack[gi] = ack_phase && (id_reg == id_t'(gi));
    end
  endgenerate

  // Rotating priority scan: offset 0 is the requester at the rr pointer.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    idx    = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      cand = idx[ID_W-1:0];
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        sel_id = cand;
      end
    end
  end

  assign ptr_after = (id_reg == id_t'(NUM_REQ-1)) ? '0 : id_reg + id_t'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    data_next    = data_reg;
    tx_byte_next = tx_byte_reg;
    timeout_next = 1'b0;
    case (state_reg)
      HOLD: begin
        if (cnt_reg == cnt_t'(HOLD_CYCLES-1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + cnt_t'(1);
        end
      end
      IDLE: begin
        if (found) begin
          id_next   = sel_id;
          data_next = req_bytes[sel_id];
          if (TAG_EN != 0) begin
            state_next   = SEND_TAG;
            tx_byte_next = 8'hF0 | 8'(sel_id);
          end else begin
            state_next   = SEND_DATA;
            tx_byte_next = req_bytes[sel_id];
          end
        end
      end
      SEND_TAG: begin
        state_next = WAIT_TAG;
        cnt_next   = '0;
      end
      SEND_DATA: begin
        state_next = WAIT_DATA;
        cnt_next   = '0;
      end
      WAIT_TAG, WAIT_DATA: begin
        // Done is checked first so it wins over a same-cycle timeout.
        if (i_TX_Done) begin
          if (state_reg == WAIT_TAG) begin
            state_next   = SEND_DATA;
            tx_byte_next = data_reg;
          end else begin
            state_next = IDLE;
            ptr_next   = ptr_after;
          end
        end else if (cnt_reg == cnt_t'(TIMEOUT_CYCLES-1)) begin
          state_next   = IDLE;
          ptr_next     = ptr_after;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + cnt_t'(1);
        end
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= HOLD;
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      id_reg      <= '0;
      data_reg    <= 8'h00;
      tx_byte_reg <= 8'h00;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      data_reg    <= data_next;
      tx_byte_reg <= tx_byte_next;
      timeout_reg <= timeout_next;
    end
  end

  // The ack lands on the first strobe of the frame, whichever byte that is.
  assign ack_phase = (TAG_EN != 0) ? (state_reg == SEND_TAG) : (state_reg == SEND_DATA);

  assign o_TX_Data_Valid = (state_reg == SEND_TAG) || (state_reg == SEND_DATA);
  assign o_TX_Byte       = tx_byte_reg;
  assign o_grant_id      = id_reg;
  assign o_busy          = (state_reg != IDLE);
  assign o_timeout       = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a tagged instance at the production bit rate and an
// untagged instance at a short bit rate, driven by vector tables, hand sequences and random frames.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Tagged instance, CLOCKS_PER_BIT = 217
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  ack;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  // Untagged instance, CLOCKS_PER_BIT = 4 (hold 44, timeout after 48 wait cycles)
  logic        rst_n_b = 1'b0;
  logic [3:0]  req_valid_b = '0;
  logic [31:0] req_byte_b = '0;
  logic [3:0]  ack_b;
  logic        txv_b;
  logic [7:0]  txb_b;
  logic        done_b = 1'b0;
  logic [1:0]  grant_b;
  logic        busy_b;
  logic        timeout_b;

  uart_tx_arbiter #(.NUM_REQ(4), .CLOCKS_PER_BIT(217), .TAG_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_byte(req_byte),
    .o_req_ack(ack), .o_TX_Data_Valid(tx_valid), .o_TX_Byte(tx_byte),
    .i_TX_Done(tx_done), .o_grant_id(grant), .o_busy(busy), .o_timeout(timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .CLOCKS_PER_BIT(4), .TAG_EN(0)) dut_nt (
    .clk(clk), .rst_n(rst_n_b), .i_req_valid(req_valid_b), .i_req_byte(req_byte_b),
    .o_req_ack(ack_b), .o_TX_Data_Valid(txv_b), .o_TX_Byte(txb_b),
    .i_TX_Done(done_b), .o_grant_id(grant_b), .o_busy(busy_b), .o_timeout(timeout_b)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] bytes;
    int          exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first asserted valid at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic wait_strobe(input int max_cycles);
    int n;
    n = 0;
    while (!tx_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("strobe_seen", tx_valid, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", ack, 0);
    check("rst_strobe", tx_valid, 0);
    check("rst_byte", tx_byte, 0);
    check("rst_grant", grant, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 1);
  endtask

  // From the last reset edge: 2387 HOLD cycles, one IDLE cycle, then the strobe.
  task automatic count_hold();
    int n;
    int busy_low;
    n = 0;
    busy_low = 0;
    while (!tx_valid && n < 3000) begin
      tick();
      n++;
      if (n < 2387 && !busy) busy_low++;
    end
    check("hold_len", n, 2388);
    check("busy_in_hold", busy_low, 0);
  endtask

  // One frame on the tagged instance, starting at (or just before) its tag strobe.
  task automatic serve_frame(input int exp_id, input logic [7:0] exp_data, input logic [3:0] drop_mask,
                             input int tag_dly, input int data_dly, input bit abort);
    int n;
    int strobes;
    wait_strobe(20);
    check("tag_byte", tx_byte, 32'hF0 | exp_id);
    check("ack_onehot", ack, 1 << exp_id);
    check("grant_id", grant, exp_id);
    req_valid = req_valid & ~drop_mask;
    $display("frame: grant=%0d tag=%02h data=%02h abort=%0d", exp_id, 8'hF0 | exp_id, exp_data, abort);
    if (abort) begin
      n = 0;
      strobes = 0;
      while (!timeout && n < 3000) begin
        tick();
        n++;
        if (tx_valid) strobes++;
      end
      check("timeout_latency", n, 2605);
      check("no_data_strobe", strobes, 0);
      check("idle_at_timeout", busy, 0);
    end else begin
      tick();
      check("ack_one_cycle", ack, 0);
      check("strobe_one_cycle", tx_valid, 0);
      check("byte_hold", tx_byte, 32'hF0 | exp_id);
      repeat (tag_dly - 1) tick();
      pulse_done();
      check("data_strobe", tx_valid, 1);
      check("data_byte", tx_byte, exp_data);
      check("no_ack_on_data", ack, 0);
      tick();
      repeat (data_dly - 1) tick();
      pulse_done();
      check("idle_after_done", busy, 0);
      check("no_timeout", timeout, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int strobes;
    int ptr_m;
    int id;
    int aborts;
    logic [3:0]  v;
    logic [31:0] b;
    bit ab;

    vecs[0] = '{4'b0100, 32'h005A0000, 2, 8'h5A};
    vecs[1] = '{4'b0011, 32'h0000C3B7, 0, 8'hB7};
    vecs[2] = '{4'b1110, 32'h9E8D7C00, 1, 8'h7C};
    vecs[3] = '{4'b0010, 32'h00004100, 1, 8'h41};
    vecs[4] = '{4'b1001, 32'hE2000001, 3, 8'hE2};

    // Reset release with requester 0 already valid
    req_valid = 4'b0001;
    req_byte  = 32'h0;
    tick();
    tick();
    check_reset_outputs();
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    count_hold();
    serve_frame(0, 8'h00, 4'hF, 1, 1, 0);

    // Untagged instance: stray dones in IDLE and in the strobe cycle
    done_b = 1'b1;
    tick();
    check("nt_stray_idle_busy", busy_b, 0);
    check("nt_stray_idle_strobe", txv_b, 0);
    req_valid_b = 4'b0010;
    req_byte_b  = 32'h0000A500;
    tick();
    check("nt_strobe", txv_b, 1);
    check("nt_byte", txb_b, 8'hA5);
    check("nt_ack", ack_b, 4'b0010);
    check("nt_grant", grant_b, 1);
    req_valid_b = 4'b0000;
    tick();
    check("nt_stray_send_ignored", busy_b, 1);
    done_b = 1'b0;
    strobes = 0;
    repeat (3) begin
      tick();
      if (txv_b) strobes++;
    end
    check("nt_wait_holds", busy_b, 1);
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check("nt_idle_after_done", busy_b, 0);
    check("nt_single_strobe", strobes, 0);

    // Untagged: done on the last wait cycle beats the timeout (pointer now 2)
    req_valid_b = 4'b0001;
    req_byte_b  = 32'h0000003E;
    tick();
    check("nt_race_grant", grant_b, 0);
    check("nt_race_byte", txb_b, 8'h3E);
    req_valid_b = 4'b0000;
    repeat (48) tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check("nt_done_beats_timeout", timeout_b, 0);
    check("nt_race_idle", busy_b, 0);

    // Untagged: timeout after 1+48 cycles, pointer advances past the aborted requester
    req_valid_b = 4'b0100;
    req_byte_b  = 32'h00550000;
    tick();
    check("nt_to_grant", grant_b, 2);
    req_valid_b = 4'b0000;
    n = 0;
    while (!timeout_b && n < 200) begin
      tick();
      n++;
    end
    check("nt_timeout_latency", n, 49);
    req_valid_b = 4'b0101;
    req_byte_b  = 32'h00200010;
    tick();
    check("nt_after_to_grant", grant_b, 0);
    check("nt_after_to_byte", txb_b, 8'h10);
    req_valid_b = 4'b0000;
    tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check("nt_final_idle", busy_b, 0);

    // Table of single frames on the tagged instance (pointer starts at 1)
    for (int i = 0; i < 5; i++) begin
      req_byte  = vecs[i].bytes;
      req_valid = vecs[i].valid;
      serve_frame(vecs[i].exp_id, vecs[i].exp_data, 4'hF, 2, 3, 0);
    end

    // All four continuously valid: order 0,1,2,3,0 with back-to-back frames
    req_byte  = 32'h44332211;
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      b = 32'h44332211;
      serve_frame(f % 4, b[8*(f%4) +: 8], (f == 4) ? 4'hF : 4'h0, 1 + f, 2, 0);
      if (f < 4) begin
        tick();
        check("next_strobe_gap", tx_valid, 1);
      end
    end

    // Transmitter never finishes the 0xF1 tag
    req_byte  = 32'h00007700;
    req_valid = 4'b0010;
    serve_frame(1, 8'h77, 4'hF, 0, 0, 1);
    req_byte  = 32'h002B6600;
    req_valid = 4'b0110;
    serve_frame(2, 8'h2B, 4'hF, 1, 1, 0);

    // Reset during WAIT_DATA abandons the frame and restarts from pointer 0
    req_byte  = 32'h3C008100;
    req_valid = 4'b1000;
    wait_strobe(20);
    check("pre_rst_tag", tx_byte, 8'hF3);
    req_valid = 4'b0000;
    tick();
    pulse_done();
    check("pre_rst_data", tx_byte, 8'h3C);
    tick();
    req_valid = 4'b1010;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs();
    count_hold();
    serve_frame(1, 8'h81, 4'hF, 1, 1, 0);

    // Random frames against the round-robin model
    ptr_m  = 2;
    aborts = 0;
    for (int f = 0; f < 16; f++) begin
      v  = 4'($urandom_range(1, 15));
      b  = $urandom;
      ab = (aborts < 2) && ($urandom_range(0, 7) == 0);
      if (ab) aborts++;
      id = rr_pick(v, ptr_m);
      req_byte  = b;
      req_valid = v;
      serve_frame(id, b[8*id +: 8], 4'hF, $urandom_range(1, 6), $urandom_range(1, 6), ab);
      ptr_m = (id + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` byte-producing requesters using round-robin arbitration. It sequences each grant as a single frame: an optional source-tag byte followed by the requester's data byte. The block sits between the requesters and the transmitter's data-valid/byte/done handshake, and guards against a transmitter that never reports done.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..16
- `CLOCKS_PER_BIT`, 217 — must equal the transmitter's setting; sets holdoff and timeout
- `TAG_EN`, 1 — 1: send tag byte `8'hF0 | id` before the data byte; 0: data byte only
- `clk`  in  1  — single clock
- `rst_n`  in  1  — reset, synchronous, active-low
- `i_req_valid`  in  NUM_REQ  — bit k: requester k has a byte pending
- `i_req_byte`  in  8*NUM_REQ  — requester k byte at [8k+7:8k]
- `o_req_ack`  out  NUM_REQ  — one-hot, one-cycle pulse: byte of k captured
- `o_TX_Data_Valid`  out  1  — one-cycle strobe to transmitter
- `o_TX_Byte`  out  8  — byte to transmitter
- `i_TX_Done`  in  1  — transmitter done pulse
- `o_grant_id`  out  $clog2(NUM_REQ)  — current/last granted requester
- `o_busy`  out  1  — state != IDLE
- `o_timeout`  out  1  — one-cycle pulse: frame aborted on timeout

## Operation
- States: HOLD, IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA. Moore outputs.
- Reset values: state=HOLD, `o_req_ack`=0, `o_TX_Data_Valid`=0, `o_TX_Byte`=8'h00, `o_grant_id`=0, `o_timeout`=0, `o_busy`=1, rr pointer=0, counter=0.
- HOLD: counts `11*CLOCKS_PER_BIT` cycles, then goes to IDLE. This lets a transmitter frame abandoned by reset finish before the first grant.
- IDLE: scans requesters starting at the rr pointer, wrapping modulo NUM_REQ, and takes the first asserted valid.
  - Captures that requester's byte and id.
  - Goes to SEND_TAG (TAG_EN=1) or SEND_DATA (TAG_EN=0).
  - With no valid asserted, stays in IDLE.
- SEND_TAG: asserts `o_TX_Data_Valid`=1 with `o_TX_Byte`=`8'hF0|id`, then goes to WAIT_TAG.
- SEND_DATA: asserts `o_TX_Data_Valid`=1 with `o_TX_Byte`=captured byte, then goes to WAIT_DATA.
- `o_req_ack[id]` is 1 in the first SEND_* cycle of the frame.
  - The requester must drop or replace valid/byte at the edge ending the ack cycle.
- `o_TX_Byte` holds stable from the strobe until the next strobe.
- WAIT_TAG goes to SEND_DATA on `i_TX_Done`. WAIT_DATA goes to IDLE on `i_TX_Done`, and the rr pointer becomes (id+1) mod NUM_REQ.
- Timeout:
  - The counter clears on entry to each WAIT_* state and increments every WAIT cycle.
  - At count `12*CLOCKS_PER_BIT-1` with no done, the block goes to IDLE, pulses `o_timeout` in that first IDLE cycle, and advances the rr pointer.
  - No retry; the byte is dropped.
- `i_TX_Done` is ignored in HOLD, IDLE and SEND_* states.
- `i_TX_Done` wins over timeout when both occur in the same cycle.
- `rst_n` low in any state returns all outputs to their reset values on the next edge, abandons the frame without an ack, and enters HOLD.

## Timing
- Valid seen in IDLE at cycle t: strobe and ack at t+1, WAIT at t+2.
- Done at cycle d in WAIT_TAG: data strobe at d+1.
- Done at d2 in WAIT_DATA: IDLE at d2+1; the next strobe is at d2+2 at the earliest.
- Timeout: strobe at s, WAIT count 0 at s+1, abort to IDLE with `o_timeout` at s+1+12*CLOCKS_PER_BIT.
- At most one strobe per 2 cycles; never more than one frame in flight.

## Test plan
- Reset release with `i_req_valid`=4'b0001 held: no strobe for 2387 cycles (11*217); then strobe 0xF0, then 0x00-byte frame; `o_busy`=1 throughout HOLD.
- TAG_EN=1, requester 2 offers 0x5A once: strobes 0xF2 then 0x5A; `o_req_ack`=4'b0100 for one cycle coincident with the 0xF2 strobe; `o_grant_id`=2; rr pointer becomes 3.
- All four valid continuously with bytes 0x11/0x22/0x33/0x44: grant order 0,1,2,3,0; each ack exactly once per frame; next strobe exactly 2 cycles after each data done.
- Transmitter model never pulses done after the 0xF1 tag: `o_timeout` pulse 2605 cycles after the strobe; no data strobe; next grant goes to requester 2.
- TAG_EN=0, byte 0xA5 on requester 1, with stray done pulses in IDLE and in the strobe cycle: single 0xA5 strobe; stray dones ignored; IDLE only after the real done.
- `rst_n` low for one cycle during WAIT_DATA: next cycle all outputs at reset values and state HOLD; no strobe for 2387 cycles; pending requester is served afterwards starting from pointer 0.
